// File: rtl/sum_collect.sv
// sum_collect: gathers an LSB-first bit-serial sum and its carry from two 4-phase channels into a valid/ready word.
module sum_collect #(
  parameter int   WIDTH       = 8,
  parameter logic Rpol        = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r_i,
  output logic             a_i,
  input  logic             d_i,
  input  logic             rc_i,
  output logic             ac_i,
  input  logic             dc_i,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [2:0] {S_BIT, S_BIT_REL, S_CARRY, S_CARRY_REL, S_OUT} state_t;
  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [SYNC_STAGES-1:0] rs_q, rs_d, cs_q, cs_d;
  logic                   a_q, a_d, ac_q, ac_d, valid_q, valid_d, cout_q, cout_d;
  logic [WIDTH-1:0]       sum_q, sum_d;
  logic                   r_act, c_act, last;
  assign r_act = rs_q[SYNC_STAGES-1] != Rpol;
  assign c_act = cs_q[SYNC_STAGES-1] != Rpol;
  assign last  = idx_q == IW'(WIDTH - 1);
  always_comb begin
    rs_d    = {rs_q[SYNC_STAGES-2:0], r_i};
    cs_d    = {cs_q[SYNC_STAGES-2:0], rc_i};
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    ac_d    = ac_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_BIT: if (r_act) begin
        sum_d[idx_q] = d_i;
        a_d          = ~Rpol;
        state_d      = S_BIT_REL;
      end
      S_BIT_REL: if (!r_act) begin
        a_d     = Rpol;
        idx_d   = last ? '0 : idx_q + 1'b1;
        state_d = last ? S_CARRY : S_BIT;
      end
      S_CARRY: if (c_act) begin
        cout_d  = dc_i;
        ac_d    = ~Rpol;
        state_d = S_CARRY_REL;
      end
      S_CARRY_REL: if (!c_act) begin
        ac_d    = Rpol;
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: if (o_ready) begin
        valid_d = 1'b0;
        state_d = S_BIT;
      end
      default: state_d = S_BIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BIT;
      idx_q   <= '0;
      rs_q    <= {SYNC_STAGES{Rpol}};
      cs_q    <= {SYNC_STAGES{Rpol}};
      a_q     <= Rpol;
      ac_q    <= Rpol;
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      cs_q    <= cs_d;
      a_q     <= a_d;
      ac_q    <= ac_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign a_i     = a_q;
  assign ac_i    = ac_q;
  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;
endmodule

// File: tb/tb_sum_collect.sv
// tb_sum_collect: three instances (8b/idle-low/2 sync, 8b/idle-low/3 sync, 4b/idle-high/2 sync) with a word scoreboard.
module tb_sum_collect;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] r   = 3'b100;
  logic [2:0] rc  = 3'b100;
  logic [2:0] d   = 3'b000;
  logic [2:0] dc  = 3'b000;
  logic [2:0] rdy = 3'b111;
  wire  [2:0] a, ac, vld, co;
  wire  [7:0] sum0, sum1;
  wire  [3:0] sum2;
  int checks = 0;
  int errors = 0;
  typedef struct { int k; logic [7:0] s; logic c; } exp_t;
  typedef struct { int k; logic [7:0] w; logic c; } vec_t;
  exp_t q[$];
  logic [2:0] prev_xfer = 3'b000;

  always #5 clk = ~clk;

  sum_collect #(.WIDTH(8), .Rpol(1'b0), .SYNC_STAGES(2)) u0 (.clk(clk), .rst(rst), .r_i(r[0]), .a_i(a[0]),
    .d_i(d[0]), .rc_i(rc[0]), .ac_i(ac[0]), .dc_i(dc[0]), .o_valid(vld[0]), .o_ready(rdy[0]), .o_sum(sum0), .o_cout(co[0]));
  sum_collect #(.WIDTH(8), .Rpol(1'b0), .SYNC_STAGES(3)) u1 (.clk(clk), .rst(rst), .r_i(r[1]), .a_i(a[1]),
    .d_i(d[1]), .rc_i(rc[1]), .ac_i(ac[1]), .dc_i(dc[1]), .o_valid(vld[1]), .o_ready(rdy[1]), .o_sum(sum1), .o_cout(co[1]));
  sum_collect #(.WIDTH(4), .Rpol(1'b1), .SYNC_STAGES(2)) u2 (.clk(clk), .rst(rst), .r_i(r[2]), .a_i(a[2]),
    .d_i(d[2]), .rc_i(rc[2]), .ac_i(ac[2]), .dc_i(dc[2]), .o_valid(vld[2]), .o_ready(rdy[2]), .o_sum(sum2), .o_cout(co[2]));

  function automatic logic pol(input int k); return k == 2; endfunction
  function automatic int width(input int k); return k == 2 ? 4 : 8; endfunction
  function automatic int lat(input int k); return k == 1 ? 4 : 3; endfunction
  function automatic logic [7:0] sum_of(input int k); return k == 0 ? sum0 : k == 1 ? sum1 : {4'h0, sum2}; endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      if (prev_xfer[k]) chk($sformatf("valid_pulse%0d", k), {31'b0, vld[k]}, 32'd0);
      prev_xfer[k] = vld[k] && rdy[k];
      if (vld[k] && rdy[k]) begin
        if (q.size() == 0) chk($sformatf("unexpected_word%0d", k), 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("word_inst", k, e.k);
          chk($sformatf("o_sum%0d", k), {24'b0, sum_of(k)}, {24'b0, e.s});
          chk($sformatf("o_cout%0d", k), {31'b0, co[k]}, {31'b0, e.c});
        end
      end
    end
  end

  // sel: 0 = a_i, 1 = ac_i, 2 = o_valid; n = posedges until the level appears
  task automatic wait_lvl(input int k, input int sel, input logic lvl, output int n);
    logic v;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      v = sel == 0 ? a[k] : sel == 1 ? ac[k] : vld[k];
    end while (v !== lvl && n < 200);
    chk($sformatf("wait%0d_sel%0d", k, sel), {31'b0, v}, {31'b0, lvl});
  endtask

  task automatic send_bit(input int k, input logic b, input bit check_lat);
    int n;
    d[k] = b;
    r[k] = ~pol(k);
    wait_lvl(k, 0, ~pol(k), n);
    if (check_lat) chk($sformatf("ack_latency%0d", k), n, lat(k));
    r[k] = pol(k);
    wait_lvl(k, 0, pol(k), n);
  endtask

  task automatic send_carry(input int k, input logic c);
    int n;
    dc[k] = c;
    rc[k] = ~pol(k);
    wait_lvl(k, 1, ~pol(k), n);
    rc[k] = pol(k);
    wait_lvl(k, 1, pol(k), n);
  endtask

  task automatic push(input int k, input logic [7:0] w, input logic c);
    exp_t e;
    e.k = k; e.s = w; e.c = c;
    q.push_back(e);
  endtask

  task automatic drain(input int k);
    int n;
    wait_lvl(k, 2, 1'b0, n);
  endtask

  task automatic check_reset(input int k);
    chk($sformatf("rst_a%0d", k), {31'b0, a[k]}, {31'b0, pol(k)});
    chk($sformatf("rst_ac%0d", k), {31'b0, ac[k]}, {31'b0, pol(k)});
    chk($sformatf("rst_valid%0d", k), {31'b0, vld[k]}, 32'd0);
    chk($sformatf("rst_sum%0d", k), {24'b0, sum_of(k)}, 32'd0);
    chk($sformatf("rst_cout%0d", k), {31'b0, co[k]}, 32'd0);
  endtask

  initial begin
    vec_t tbl[7];
    logic [7:0] w;
    int n;
    tbl[0] = '{0, 8'hA5, 1'b1};
    tbl[1] = '{0, 8'h3C, 1'b0};
    tbl[2] = '{0, 8'hFF, 1'b1};
    tbl[3] = '{0, 8'h00, 1'b0};
    tbl[4] = '{2, 8'h09, 1'b0};
    tbl[5] = '{2, 8'h0F, 1'b1};
    tbl[6] = '{1, 8'h5A, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_reset(k);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push(tbl[i].k, tbl[i].w, tbl[i].c);
      for (int b = 0; b < width(tbl[i].k); b++) send_bit(tbl[i].k, tbl[i].w[b], 1'b1);
      send_carry(tbl[i].k, tbl[i].c);
      drain(tbl[i].k);
    end
    // backpressure: word held while the next word's first bit waits unacknowledged
    rdy[0] = 1'b0;
    push(0, 8'h11, 1'b1);
    w = 8'h11;
    for (int b = 0; b < 8; b++) send_bit(0, w[b], 1'b0);
    send_carry(0, 1'b1);
    w = 8'h3C;
    d[0] = w[0];
    r[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_a", {31'b0, a[0]}, 32'd0);
    chk("bp_valid", {31'b0, vld[0]}, 32'd1);
    chk("bp_sum", {24'b0, sum0}, 32'h11);
    chk("bp_cout", {31'b0, co[0]}, 32'd1);
    push(0, 8'h3C, 1'b0);
    rdy[0] = 1'b1;
    wait_lvl(0, 0, 1'b1, n);
    r[0] = 1'b0;
    wait_lvl(0, 0, 1'b0, n);
    for (int b = 1; b < 8; b++) send_bit(0, w[b], 1'b1);
    send_carry(0, 1'b0);
    drain(0);
    // early carry after bit 3 waits for the whole word
    w = 8'h96;
    push(0, w, 1'b1);
    for (int b = 0; b < 4; b++) send_bit(0, w[b], 1'b1);
    dc[0] = 1'b1;
    rc[0] = 1'b1;
    for (int b = 4; b < 8; b++) begin
      send_bit(0, w[b], 1'b1);
      chk($sformatf("early_ac_bit%0d", b), {31'b0, ac[0]}, 32'd0);
    end
    wait_lvl(0, 1, 1'b1, n);
    chk("early_ac_delay", n, 1);
    rc[0] = 1'b0;
    wait_lvl(0, 1, 1'b0, n);
    drain(0);
    // reset mid-word with the request held across reset
    w = 8'h1F;
    for (int b = 0; b < 5; b++) send_bit(0, w[b], 1'b1);
    d[0] = 1'b1;
    r[0] = 1'b1;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_reset(0);
    end
    rst = 1'b0;
    w = 8'hC3;
    push(0, w, 1'b1);
    wait_lvl(0, 0, 1'b1, n);
    chk("post_rst_latency", n, 3);
    r[0] = 1'b0;
    wait_lvl(0, 0, 1'b0, n);
    for (int b = 1; b < 8; b++) send_bit(0, w[b], 1'b1);
    send_carry(0, 1'b1);
    drain(0);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sum_collect.md
SUM_COLLECT -- requirements
Module: sum_collect

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of sum bits per word (legal range 2..32).
REQ-002 The block SHALL have parameter Rpol, default 1'b0, giving the idle (reset) level of every request and acknowledge wire.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, giving the flop depth of each request synchronizer (legal range 2..3).
REQ-004 One clock and a synchronous, active-high reset: clk input, 1 bit, rising-edge clock; rst input, 1 bit, synchronous, active-high.
REQ-005 r_i  input  1  sum-channel request, asynchronous 4-phase.
REQ-006 a_i  output  1  sum-channel acknowledge.
REQ-007 d_i  input  1  sum bit, bundled with r_i, LSB first.
REQ-008 rc_i  input  1  carry-channel request, asynchronous 4-phase.
REQ-009 ac_i  output  1  carry-channel acknowledge.
REQ-010 dc_i  input  1  final carry-out bit, bundled with rc_i.
REQ-011 o_valid  output  1  assembled word available.
REQ-012 o_ready  input  1  consumer accepts the word.
REQ-013 o_sum  output  WIDTH  assembled sum word, bit 0 = first bit received.
REQ-014 o_cout  output  1  carry-out of the word.

Function
REQ-015 A request SHALL be active when it differs from Rpol; r_i and rc_i SHALL each pass through a SYNC_STAGES-flop synchronizer before any use.
REQ-016 The state machine SHALL have states S_BIT, S_BIT_REL, S_CARRY, S_CARRY_REL, S_OUT; the reset state is S_BIT with bit counter idx=0.
REQ-017 In S_BIT, on the cycle synchronized r_i is active: capture d_i into o_sum[idx], drive a_i to ~Rpol, and go to S_BIT_REL.
REQ-018 In S_BIT_REL, when synchronized r_i returns to Rpol: drive a_i to Rpol. If idx==WIDTH-1, go to S_CARRY with idx=0; otherwise increment idx and go to S_BIT.
REQ-019 In S_CARRY, on the cycle synchronized rc_i is active: capture dc_i into o_cout, drive ac_i to ~Rpol, and go to S_CARRY_REL.
REQ-020 In S_CARRY_REL, when synchronized rc_i returns to Rpol: drive ac_i to Rpol and go to S_OUT with o_valid=1.
REQ-021 In S_OUT, o_valid, o_sum and o_cout SHALL hold stable until the cycle o_valid&&o_ready; on that cycle o_valid goes to 0 on the next edge and the state returns to S_BIT.
REQ-022 Outside S_BIT, an active sum request SHALL NOT be acknowledged; it stays pending. Sum requests are therefore backpressured during the carry phase and while o_valid is held.
REQ-023 Outside S_CARRY, an active carry request SHALL NOT be acknowledged; an early carry waits until all WIDTH bits are collected.
REQ-024 a_i and ac_i SHALL be driven directly from flops, glitch-free, and change at most once per handshake phase.
REQ-025 Latency from r_i going active to a_i going active SHALL be SYNC_STAGES+1 cycles. The last carry release SHALL reach o_valid in SYNC_STAGES+1 cycles.
REQ-026 A new word's first sum bit MAY begin its handshake on the cycle after the o_valid&&o_ready transfer, with no idle bubble required beyond the synchronizer delay.

Reset
REQ-027 While rst is high at a clk edge, the block SHALL set: a_i=Rpol, ac_i=Rpol, o_valid=0, o_sum=0, o_cout=0, state=S_BIT, idx=0, and all synchronizer flops to Rpol.
REQ-028 Reset mid-word SHALL discard the partial word. A request still active after reset SHALL be treated as a new first-bit (or early carry) token.

Verification
REQ-029 WIDTH=8, Rpol=0: send bits LSB-first for 0xA5, then carry 1, with o_ready=1 -> o_valid pulses for one cycle with o_sum=0xA5, o_cout=1.
REQ-030 Hold o_ready=0 after a word and start the next word's bit -> a_i stays 0 and the word stays stable until o_ready=1; then the second word 0x3C/cout 0 completes correctly.
REQ-031 Assert rc_i after bit 3 of 8 -> ac_i stays 0 until bit 7's handshake completes, then the carry is acknowledged and captured.
REQ-032 Assert rst after 5 bits, with r_i held high across reset -> outputs reach their reset values; after reset the held request is captured as bit 0 of a new word.
REQ-033 Rpol=1, WIDTH=4: all handshakes idle high; word 0x9 with carry 0 -> o_sum=0x9, o_cout=0, and a_i/ac_i return to 1 between tokens.
REQ-034 Measure the r_i-active to a_i-active delay with SYNC_STAGES=2 and =3 -> 3 and 4 cycles respectively.
